des_key_sequencer: RTL and testbench

Sequencer that drives the team's combinational key shifter through a full 16-round DES key schedule. It loads a 64-bit key and applies PC-1 to form C0/D0. It then steps the shifter once per accepted round, holding the C/D state between steps, and presents each 48-bit round key to the round engine over a valid/ready handshake. It sits between the key input port and the DES round datapath, and owns both the round counter and the encrypt/decrypt direction.

---
 rtl/des_key_sequencer.sv | 133 +++++++++++++
 tb/tb_des_key_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sequencer.sv
// ============================================================================
// des_key_sequencer : loads a DES key through PC-1, then steps the external
//                     key shifter once per accepted round over valid/ready.
// Revision 1.0
// ============================================================================
`default_nettype none

module des_key_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mode,
   input  logic [63:0] key_in,
   input  logic        abort,
   input  logic        key_ready,
   output logic        key_valid,
   output logic [47:0] key_out,
   output logic [3:0]  key_round,
   output logic        key_last,
   output logic        busy,
   output logic        done,
   output logic        sh_mode,
   output logic [3:0]  sh_round,
   output logic [27:0] sh_ci,
   output logic [27:0] sh_di,
   input  logic [27:0] sh_ci_next,
   input  logic [27:0] sh_di_next,
   input  logic [47:0] sh_key
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // FIPS 46-3 PC-1: entry j names the DES key bit (1 = key_in[63]) feeding C/D bit j.
   localparam int unsigned PC1_TBL [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [5:0] src;
      pc1 = '0;
      for (int j = 0; j < 56; j++) begin
         src = 6'(64 - PC1_TBL[j]);
         pc1[55-j] = k[src];
      end
   endfunction

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        mode_q, mode_d;
   logic [55:0] pc1_key;

   assign pc1_key = pc1(key_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
      mode_d  = mode_q;
      if (abort) begin
         state_d = S_IDLE;
         round_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  c_d     = pc1_key[55:28];
                  d_d     = pc1_key[27:0];
                  round_d = '0;
                  mode_d  = mode;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (key_ready) begin
                  c_d     = sh_ci_next;
                  d_d     = sh_di_next;
                  round_d = round_q + 4'd1;
                  if (round_q == 4'd15) begin
                     state_d = S_FIN;
                  end
               end
            end
            S_FIN: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Round key comes straight from the shifter, so it is stable across stalls.
   assign key_valid = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_FIN);
   assign key_out   = sh_key;
   assign key_round = round_q;
   assign key_last  = key_valid && (round_q == 4'd15);
   assign sh_mode   = mode_q;
   assign sh_round  = round_q;
   assign sh_ci     = c_q;
   assign sh_di     = d_q;

endmodule

`default_nettype wire

// File: tb/tb_des_key_sequencer.sv
// ============================================================================
// tb_des_key_sequencer : directed bench with a key-schedule model and a
//                        stand-in for the combinational key shifter.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_des_key_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [63:0] key_in;
   logic        abort;
   logic        key_ready;
   logic        key_valid;
   logic [47:0] key_out;
   logic [3:0]  key_round;
   logic        key_last;
   logic        busy;
   logic        done;
   logic        sh_mode;
   logic [3:0]  sh_round;
   logic [27:0] sh_ci;
   logic [27:0] sh_di;
   logic [27:0] sh_ci_next;
   logic [27:0] sh_di_next;
   logic [47:0] sh_key;

   always #5 clk = ~clk;

   des_key_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .key_in     (key_in),
      .abort      (abort),
      .key_ready  (key_ready),
      .key_valid  (key_valid),
      .key_out    (key_out),
      .key_round  (key_round),
      .key_last   (key_last),
      .busy       (busy),
      .done       (done),
      .sh_mode    (sh_mode),
      .sh_round   (sh_round),
      .sh_ci      (sh_ci),
      .sh_di      (sh_di),
      .sh_ci_next (sh_ci_next),
      .sh_di_next (sh_di_next),
      .sh_key     (sh_key)
   );

   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SH [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
   localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

   function automatic logic [55:0] f_pc1(input logic [63:0] k);
      f_pc1 = '0;
      for (int j = 0; j < 56; j++) f_pc1[55-j] = k[64-PC1[j]];
   endfunction

   function automatic logic [47:0] f_pc2(input logic [55:0] cd);
      f_pc2 = '0;
      for (int j = 0; j < 48; j++) f_pc2[47-j] = cd[56-PC2[j]];
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      logic [55:0] t;
      t = {x, x} << n;
      return t[55:28];
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      logic [55:0] t;
      t = {x, x} >> n;
      return t[27:0];
   endfunction

   // Stand-in for the external shifter: one round's rotation from the live C/D.
   int sh_amt;
   always_comb begin
      sh_amt = 0;
      if (sh_mode) sh_amt = SH[sh_round];
      else if (sh_round != 4'd0) sh_amt = SH[16 - int'(sh_round)];
      sh_ci_next = sh_mode ? rotl28(sh_ci, sh_amt) : rotr28(sh_ci, sh_amt);
      sh_di_next = sh_mode ? rotl28(sh_di, sh_amt) : rotr28(sh_di, sh_amt);
      sh_key     = f_pc2({sh_ci_next, sh_di_next});
   end

   // Reference schedule: encrypt key i uses the total rotation up to round i;
   // decrypt delivers the encrypt keys in reverse order.
   function automatic logic [47:0] sched_key(input logic [63:0] k, input logic m, input int r);
      logic [55:0] cd0;
      int          e;
      int          tot;
      cd0 = f_pc1(k);
      e   = m ? r : 15 - r;
      tot = 0;
      for (int i = 0; i <= e; i++) tot += SH[i];
      return f_pc2({rotl28(cd0[55:28], tot), rotl28(cd0[27:0], tot)});
   endfunction

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   logic        m_active;
   logic        m_done;
   int          m_idx;
   logic        m_mode;
   logic [47:0] m_keys [16];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_idx    <= 0;
      end else if (abort) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_idx    <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_active) begin
         if (key_ready) begin
            if (m_idx == 15) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
               m_idx    <= 0;
            end else begin
               m_idx <= m_idx + 1;
            end
         end
      end else if (start) begin
         m_active <= 1'b1;
         m_idx    <= 0;
         m_mode   <= mode;
         for (int i = 0; i < 16; i++) m_keys[i] <= sched_key(key_in, mode, i);
      end
   end

   always @(negedge clk) begin
      chk("key_valid", 64'(key_valid), 64'(m_active));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      if (m_active) begin
         chk("key_round", 64'(key_round), 64'(m_idx));
         chk("sh_round", 64'(sh_round), 64'(m_idx));
         chk("key_out", 64'(key_out), 64'(m_keys[m_idx]));
         chk("key_last", 64'(key_last), 64'(m_idx == 15));
         chk("sh_mode", 64'(sh_mode), 64'(m_mode));
      end
   end

   task automatic do_start(input logic [63:0] k, input logic m);
      start  = 1'b1;
      key_in = k;
      mode   = m;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Runs one schedule from the first RUN cycle until done; optional stall and start toggle.
   task automatic run_sched(input int stall_r, input int stall_n, input int toggle_r,
                            output int done_n, output int hs, output logic [47:0] k0,
                            output logic [47:0] k15, output logic last15, output int stable);
      int          stalled;
      logic [47:0] held;
      done_n = 0; hs = 0; k0 = '0; k15 = '0; last15 = 1'b0; stable = 0;
      stalled = 0; held = '0;
      for (int n = 1; n <= 60; n++) begin
         start = 1'b0;
         if (toggle_r >= 0 && key_valid && key_round == 4'(toggle_r)) begin
            start  = 1'b1;
            mode   = ~mode;
            key_in = ~key_in;
         end
         if (stall_n > 0 && key_valid && key_round == 4'(stall_r) && stalled < stall_n) begin
            key_ready = 1'b0;
            stalled++;
         end else begin
            key_ready = 1'b1;
         end
         @(negedge clk);
         if (key_valid && key_ready) hs++;
         if (key_valid && key_round == 4'd0) k0 = key_out;
         if (key_valid && key_round == 4'd15) begin
            k15    = key_out;
            last15 = key_last;
         end
         if (stall_n > 0 && key_valid && key_round == 4'(stall_r)) begin
            if (stable == 0) held = key_out;
            if (key_out == held) stable++;
         end
         if (done) begin
            done_n = n;
            break;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk("done_seen", 64'(done_n > 0), 64'd1);
   endtask

   int          dn, hs, st;
   logic [47:0] k0, k15;
   logic        l15;
   int          waited;

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; key_in = '0; abort = 1'b0; key_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(key_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_last", 64'(key_last), 64'd0);
      chk("rst_round", 64'(key_round), 64'd0);
      chk("rst_sh_round", 64'(sh_round), 64'd0);
      chk("rst_sh_mode", 64'(sh_mode), 64'd0);
      chk("rst_sh_ci", 64'(sh_ci), 64'd0);
      chk("rst_sh_di", 64'(sh_di), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      key_ready = 1'b1;
      @(posedge clk); #1;

      // Encrypt, with a start pulse and input changes while busy.
      do_start(KEY_A, 1'b1);
      run_sched(-1, 0, 3, dn, hs, k0, k15, l15, st);
      chk("enc_k0", 64'(k0), 64'(K1_A));
      chk("enc_k15", 64'(k15), 64'(K16_A));
      chk("enc_last15", 64'(l15), 64'd1);
      chk("enc_done_cycle", 64'(dn), 64'd17);
      chk("enc_handshakes", 64'(hs), 64'd16);

      // Back-to-back restart with a different key in the IDLE cycle after FIN.
      @(posedge clk); #1;
      do_start(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_sched(-1, 0, -1, dn, hs, k0, k15, l15, st);
      chk("b2b_ones_k0", 64'(k0), 64'hFFFF_FFFF_FFFF);
      chk("b2b_ones_done", 64'(dn), 64'd17);
      @(posedge clk); #1;
      do_start(64'h0, 1'b0);
      run_sched(-1, 0, -1, dn, hs, k0, k15, l15, st);
      chk("b2b_zero_k0", 64'(k0), 64'h0);
      chk("b2b_zero_k15", 64'(k15), 64'h0);

      // Decrypt, same key: keys in reverse order.
      @(posedge clk); #1;
      do_start(KEY_A, 1'b0);
      run_sched(-1, 0, -1, dn, hs, k0, k15, l15, st);
      chk("dec_k0", 64'(k0), 64'(K16_A));
      chk("dec_k15", 64'(k15), 64'(K1_A));
      chk("dec_handshakes", 64'(hs), 64'd16);
      chk("dec_done_cycle", 64'(dn), 64'd17);

      // Encrypt with three stall cycles at round 5.
      @(posedge clk); #1;
      do_start(KEY_A, 1'b1);
      run_sched(5, 3, -1, dn, hs, k0, k15, l15, st);
      chk("stall_done_cycle", 64'(dn), 64'd20);
      chk("stall_stable", 64'(st), 64'd4);
      chk("stall_k15", 64'(k15), 64'(K16_A));

      // Abort at round 7 coinciding with a handshake.
      @(posedge clk); #1;
      do_start(KEY_A, 1'b1);
      key_ready = 1'b1;
      waited = 0;
      while (!(key_valid && key_round == 4'd7) && waited < 30) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("abort_reach_r7", 64'(key_round), 64'd7);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_valid", 64'(key_valid), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_round", 64'(key_round), 64'd0);
      repeat (2) @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      do_start(KEY_A, 1'b1);
      run_sched(-1, 0, -1, dn, hs, k0, k15, l15, st);
      chk("abort_restart_k0", 64'(k0), 64'(K1_A));
      chk("abort_restart_done", 64'(dn), 64'd17);

      // Asynchronous reset at round 10.
      @(posedge clk); #1;
      do_start(KEY_A, 1'b1);
      waited = 0;
      while (!(key_valid && key_round == 4'd10) && waited < 30) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("rst_reach_r10", 64'(key_round), 64'd10);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(key_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_round", 64'(key_round), 64'd0);
      chk("arst_sh_ci", 64'(sh_ci), 64'd0);
      chk("arst_sh_di", 64'(sh_di), 64'd0);
      chk("arst_sh_mode", 64'(sh_mode), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_start(KEY_A, 1'b0);
      run_sched(-1, 0, -1, dn, hs, k0, k15, l15, st);
      chk("post_rst_k0", 64'(k0), 64'(K16_A));

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
